// File: rtl/alu_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_logic_pipe
// Description : Single-stage pipelined logic-class ALU (AND/ORR/EOR/BIC/MVN/MOV)
//               with an architectural NZCV flag register. Valid/ready handshake
//               on both the request and result sides, full throughput.
//
// Parameters  : WIDTH - operand/result width in bits (>= 2)
//               OPW   - opcode width (>= 3)
//
// Ports       : clk        in   1      clock, rising edge
//               rst_n      in   1      asynchronous active-low reset
//               in_valid   in   1      request valid
//               in_ready   out  1      unit can accept a request this cycle
//               op         in   OPW    000 AND, 001 ORR, 010 EOR, 011 BIC,
//                                      100 MVN, 101 MOV, others reserved
//               set_flags  in   1      update NZ(C) with this result
//               r2         in   WIDTH  operand 1
//               r3         in   WIDTH  operand 2
//               shtype     in   2      (SHIFT_EN) 00 LSL 01 LSR 10 ASR 11 ROR
//               shamt      in   clog2  (SHIFT_EN) shift amount for r3
//               out_valid  out  1      result valid
//               out_ready  in   1      downstream accepts result
//               r1         out  WIDTH  registered result
//               err        out  1      result came from a reserved opcode
//               n,z,c,v    out  1      architectural flag register
//
// Build macro : SHIFT_EN - adds a barrel shifter on operand 2 that also
//               drives the carry flag. Undefined by default.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           op,
    input  logic                     set_flags,
    input  logic [WIDTH-1:0]         r2,
    input  logic [WIDTH-1:0]         r3,
`ifdef SHIFT_EN
    input  logic [1:0]               shtype,
    input  logic [$clog2(WIDTH)-1:0] shamt,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         r1,
    output logic                     err,
    output logic                     n,
    output logic                     z,
    output logic                     c,
    output logic                     v
);

    // ------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------
    localparam logic [OPW-1:0] c_OP_AND = OPW'(0);
    localparam logic [OPW-1:0] c_OP_ORR = OPW'(1);
    localparam logic [OPW-1:0] c_OP_EOR = OPW'(2);
    localparam logic [OPW-1:0] c_OP_BIC = OPW'(3);
    localparam logic [OPW-1:0] c_OP_MVN = OPW'(4);
    localparam logic [OPW-1:0] c_OP_MOV = OPW'(5);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [WIDTH-1:0] r_r1;
    logic             r_err;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_drain;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH-1:0] w_result;
    logic             w_reserved;
    logic             w_c_next;

    // A new request may enter whenever the output slot is empty or is being
    // emptied in this same cycle, which gives back-to-back throughput.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_valid && out_ready;

`ifdef SHIFT_EN
    // Each shift is computed one bit wider than the operand so that the last
    // bit shifted out lands in a fixed position and can be picked up as the
    // carry without a variable index.
    logic [WIDTH:0]   w_lsl_ext;
    logic [WIDTH:0]   w_lsr_ext;
    logic [WIDTH:0]   w_asr_ext;
    logic [WIDTH-1:0] w_ror;
    logic             w_sh_carry;

    assign w_lsl_ext = {1'b0, r3} << shamt;
    assign w_lsr_ext = {r3, 1'b0} >> shamt;
    assign w_asr_ext = $unsigned($signed({r3, 1'b0}) >>> shamt);
    // With shamt==0 the left shift by WIDTH yields zero, so the OR is exact.
    assign w_ror     = (r3 >> shamt) | (r3 << (WIDTH - int'(shamt)));

    always_comb begin
        w_op2      = r3;
        w_sh_carry = 1'b0;
        case (shtype)
            2'b00: begin
                w_op2      = w_lsl_ext[WIDTH-1:0];
                w_sh_carry = w_lsl_ext[WIDTH];
            end
            2'b01: begin
                w_op2      = w_lsr_ext[WIDTH:1];
                w_sh_carry = w_lsr_ext[0];
            end
            2'b10: begin
                w_op2      = w_asr_ext[WIDTH:1];
                w_sh_carry = w_asr_ext[0];
            end
            default: begin
                w_op2      = w_ror;
                w_sh_carry = w_ror[WIDTH-1];
            end
        endcase
    end

    // A zero shift amount leaves the carry untouched.
    assign w_c_next = (shamt != '0) ? w_sh_carry : r_c;
`else
    // Without the shifter there is no carry source; c keeps its reset value.
    assign w_op2    = r3;
    assign w_c_next = r_c;
`endif

    always_comb begin
        w_result   = '0;
        w_reserved = 1'b0;
        case (op)
            c_OP_AND: w_result = r2 & w_op2;
            c_OP_ORR: w_result = r2 | w_op2;
            c_OP_EOR: w_result = r2 ^ w_op2;
            c_OP_BIC: w_result = r2 & ~w_op2;
            c_OP_MVN: w_result = ~w_op2;
            c_OP_MOV: w_result = w_op2;
            default:  w_reserved = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Result slot and flag register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_r1    <= '0;
            r_err   <= 1'b0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_r1    <= w_result;
                r_err   <= w_reserved;
                // Flags move with acceptance, not with drain, so dependent
                // flag-setting ops observe them in acceptance order. v is
                // never produced by a logic op and simply holds.
                if (set_flags && !w_reserved) begin
                    r_n <= w_result[WIDTH-1];
                    r_z <= (w_result == '0);
                    r_c <= w_c_next;
                end
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign r1        = r_r1;
    assign err       = r_err;
    assign n         = r_n;
    assign z         = r_z;
    assign c         = r_c;
    assign v         = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_logic_pipe
// Description : Self-checking bench for alu_logic_pipe. Table-driven vectors
//               feed a scoreboard queue; results are popped and compared as
//               the unit drains them. Hand sequences cover stall, reset and
//               (with SHIFT_EN) shifter carry behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_logic_pipe;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [OPW-1:0]   op = '0;
    logic             set_flags = 1'b0;
    logic [WIDTH-1:0] r2 = '0;
    logic [WIDTH-1:0] r3 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] r1;
    logic             err;
    logic             n;
    logic             z;
    logic             c;
    logic             v;
`ifdef SHIFT_EN
    logic [1:0]               shtype = 2'b00;
    logic [$clog2(WIDTH)-1:0] shamt  = '0;
`endif

    always #5 clk = ~clk;

    alu_logic_pipe #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .set_flags (set_flags),
        .r2        (r2),
        .r3        (r3),
`ifdef SHIFT_EN
        .shtype    (shtype),
        .shamt     (shamt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r1        (r1),
        .err       (err),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    typedef struct {
        logic [2:0]  op;
        logic        s;
        logic [31:0] r2;
        logic [31:0] r3;
        logic [31:0] e_r1;
        logic        e_err;
        logic        e_n;
        logic        e_z;
        logic        e_c;
    } vec_t;

    // Packed expectation: {r1, err, n, z, c, v}
    logic [WIDTH+4:0] sb_q[$];
    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int drains = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every drained result is compared with the oldest
    // expectation pushed at acceptance time.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got r1=%h with empty scoreboard", r1);
            end else begin
                logic [WIDTH+4:0] e;
                e = sb_q.pop_front();
                drains++;
                check("drain", 64'({r1, err, n, z, c, v}), 64'(e));
            end
        end
    end

    // Drive one request, wait (bounded) for acceptance, record expectation.
    task automatic send(input vec_t t);
        int k;
        in_valid  = 1'b1;
        op        = t.op;
        set_flags = t.s;
        r2        = t.r2;
        r3        = t.r3;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
        end else begin
            sb_q.push_back({t.e_r1, t.e_err, t.e_n, t.e_z, t.e_c, 1'b0});
            pushes++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_timeout_queue_size", 64'(sb_q.size()), 64'd0);
    endtask

    vec_t tbl[12];

    initial begin
        //          op      S     r2             r3             r1             err n  z  c
        tbl[0]  = '{3'b001, 1'b1, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0, 0, 0, 0};
        tbl[1]  = '{3'b001, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 1, 0, 0};
        tbl[2]  = '{3'b001, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 1, 0};
        tbl[3]  = '{3'b001, 1'b0, 32'h0000_0070, 32'h0000_000C, 32'h0000_007C, 0, 0, 1, 0};
        tbl[4]  = '{3'b000, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 1, 0, 0};
        tbl[5]  = '{3'b010, 1'b1, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0, 0, 0, 0};
        tbl[6]  = '{3'b011, 1'b0, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 0, 0, 0, 0};
        tbl[7]  = '{3'b100, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 1, 0};
        tbl[8]  = '{3'b101, 1'b1, 32'h0000_0000, 32'h8000_0001, 32'h8000_0001, 0, 1, 0, 0};
        tbl[9]  = '{3'b110, 1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0};
        tbl[10] = '{3'b111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 1, 0, 0};
        tbl[11] = '{3'b000, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0, 0, 1, 0};

        // ---------------- reset state ----------------
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_outputs", 64'({out_valid, r1, err, n, z, c, v}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", 64'({out_valid, r1, err}), 64'd0);

        // ---------------- table, full throughput ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(tbl[i]);
        wait_empty();

        // ---------------- stall: ORR 1|1 then EOR 3^1 ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b001;
        set_flags = 1'b0;
        r2        = 32'h1;
        r3        = 32'h1;
        @(negedge clk);
        check("stall_first_in_ready", 64'(in_ready), 64'd1);
        sb_q.push_back({32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        pushes++;
        @(posedge clk);
        #1;
        op = 3'b010;
        r2 = 32'h3;
        r3 = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", 64'({in_ready, out_valid, r1}), 64'({1'b0, 1'b1, 32'h1}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in_ready", 64'(in_ready), 64'd1);
        sb_q.push_back({32'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        pushes++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_empty();

        // ---------------- reserved opcode keeps flags ----------------
        send('{3'b110, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 0, 1, 0});
        wait_empty();

        // ---------------- async reset with a held result ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b001;
        set_flags = 1'b1;
        r2        = 32'h8000_0000;
        r3        = 32'h0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held_before_reset", 64'({out_valid, r1, n, z}), 64'({1'b1, 32'h8000_0000, 1'b1, 1'b0}));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 64'({out_valid, r1, err, n, z, c, v}), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send('{3'b001, 1'b1, 32'h2, 32'h1, 32'h3, 0, 0, 0, 0});
        wait_empty();

`ifdef SHIFT_EN
        // ---------------- shifter carry ----------------
        shtype = 2'b01; shamt = 5'd1;
        send('{3'b001, 1'b1, 32'h0, 32'h3, 32'h1, 0, 0, 0, 1});
        shtype = 2'b00; shamt = 5'd0;
        send('{3'b001, 1'b1, 32'h0, 32'h0, 32'h0, 0, 0, 1, 1});
        shtype = 2'b11; shamt = 5'd1;
        send('{3'b001, 1'b1, 32'h0, 32'h1, 32'h8000_0000, 0, 1, 0, 1});
        shtype = 2'b10; shamt = 5'd4;
        send('{3'b001, 1'b1, 32'h0, 32'h8000_0000, 32'hF800_0000, 0, 1, 0, 0});
        shtype = 2'b00; shamt = 5'd0;
        wait_empty();
`endif

        check("drain_count", 64'(drains), 64'(pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
